// File: rtl/dmio_pkg.sv
// Shared constants for the dmio memory-mapped I/O responder: register offsets,
// STATUS bit layout and the default window base.
package dmio_pkg;

    typedef enum logic [1:0] {
        OFF_TXDATA = 2'd0,
        OFF_STATUS = 2'd1,
        OFF_CYCLE  = 2'd2,
        OFF_CYCCTL = 2'd3
    } dmio_off_e;

    localparam int ST_EMPTY_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_OVF_BIT   = 2;
    localparam int ST_CNT_LSB   = 3;
    localparam int ST_CNT_W     = 5;

    localparam logic [7:0] DMIO_IO_BASE_DEFAULT = 8'hFC;

    function automatic logic [7:0] pack_status(
        input logic [ST_CNT_W-1:0] cnt,
        input logic                ovf,
        input logic                full,
        input logic                empty
    );
        logic [7:0] s;
        s = '0;
        s[ST_CNT_LSB +: ST_CNT_W] = cnt;
        s[ST_OVF_BIT]             = ovf;
        s[ST_FULL_BIT]            = full;
        s[ST_EMPTY_BIT]           = empty;
        return s;
    endfunction

endpackage

// File: rtl/dmio_fifo.sv
// DEPTH x DW transmit FIFO with occupancy count; a push while full and a pop
// while empty are ignored, fullness is judged on the pre-edge state.
module dmio_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == FULL_CNT);
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign count     = r_count;
    assign head      = empty ? '0 : r_mem[r_rd_ptr];

    // NOTE: the storage array has no reset; the head output is masked while
    // empty, so stale entries are never visible and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dmio.sv
// Memory-mapped I/O responder: 4-word window with TX FIFO, STATUS and an
// optional free-running cycle counter enabled by the DMIO_CYCLE_EN macro.
module dmio
    import dmio_pkg::*;
#(
    parameter int             DW      = 16,
    parameter int             AW      = 8,
    parameter logic [AW-1:0]  IO_BASE = AW'(DMIO_IO_BASE_DEFAULT),
    parameter int             DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          we,
    output logic          hit,
    output logic [DW-1:0] rdata,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          w_hit;
    dmio_off_e     w_off;
    logic          w_wr;
    logic          w_push_req;
    logic          w_ovf_clr;
    logic          w_pop;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_status;
    logic          r_ovf;

    assign w_hit      = (addr[AW-1:2] == IO_BASE[AW-1:2]);
    assign w_off      = dmio_off_e'(addr[1:0]);
    assign w_wr       = we & w_hit;
    assign w_push_req = w_wr & (w_off == OFF_TXDATA);
    assign w_ovf_clr  = w_wr & (w_off == OFF_STATUS);
    assign w_pop      = out_valid & out_ready;

    assign hit       = w_hit;
    assign out_valid = ~w_empty;

    dmio_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push_req),
        .push_data (wdata),
        .pop       (w_pop),
        .head      (out_data),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // A dropped push outranks a simultaneous clear so no overflow is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_push_req & w_full) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign w_status = pack_status(ST_CNT_W'(w_count), r_ovf, w_full, w_empty);

`ifdef DMIO_CYCLE_EN
    logic [DW-1:0] r_cycle;
    logic          r_wrap;
    logic          w_cyc_clr;

    assign w_cyc_clr = w_wr & (w_off == OFF_CYCCTL) & wdata[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle <= '0;
            r_wrap  <= 1'b0;
        end else if (w_cyc_clr) begin
            r_cycle <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_cycle <= r_cycle + DW'(1);
            if (&r_cycle) begin
                r_wrap <= 1'b1;
            end
        end
    end
`endif

    always_comb begin
        rdata = '0;
        if (w_hit) begin
            case (w_off)
                OFF_STATUS: rdata[7:0] = w_status;
`ifdef DMIO_CYCLE_EN
                OFF_CYCLE:  rdata      = r_cycle;
                OFF_CYCCTL: rdata[0]   = r_wrap;
`endif
                default:    rdata      = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmio.sv
// Self-checking bench for dmio: decode table, directed FIFO/overflow/reset
// sequences, cycle counter (with DMIO_CYCLE_EN) and randomized model checks.
module tb_dmio;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          we = 1'b0;
    logic          out_ready = 1'b0;
    logic          hit;
    logic [DW-1:0] rdata;
    logic [DW-1:0] out_data;
    logic          out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    dmio #(
        .DW      (DW),
        .AW      (AW),
        .IO_BASE (8'hFC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .hit       (hit),
        .rdata     (rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  addr;
        logic        exp_hit;
        logic        chk_rd;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t        vecs[6];
    logic [15:0] q[$];
    bit          ovf_m;
    logic [7:0]  addr_pool[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        step();
        we    = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [15:0] exp);
        addr = a;
        #1;
        check(name, 32'(rdata), 32'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        we = 1'b0;
        out_ready = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    function automatic logic [15:0] model_status(input int sz, input bit ovf);
        return 16'((sz * 8) + (ovf ? 4 : 0) + ((sz == DEPTH) ? 2 : 0) + ((sz == 0) ? 1 : 0));
    endfunction

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        step();
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        rd_chk("rst_status", 8'hFD, 16'h0001);

        // ---------------- decode table ----------------
        vecs[0] = '{8'hFB, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{8'hFC, 1'b1, 1'b1, 16'h0000};
        vecs[2] = '{8'hFD, 1'b1, 1'b1, 16'h0001};
`ifdef DMIO_CYCLE_EN
        vecs[3] = '{8'hFE, 1'b1, 1'b0, 16'h0000};
`else
        vecs[3] = '{8'hFE, 1'b1, 1'b1, 16'h0000};
`endif
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 16'h0000};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            addr = vecs[i].addr;
            #1;
            check($sformatf("tbl_hit_%h", vecs[i].addr), 32'(hit), 32'(vecs[i].exp_hit));
            if (vecs[i].chk_rd) begin
                check($sformatf("tbl_rd_%h", vecs[i].addr), 32'(rdata), 32'(vecs[i].exp_rd));
            end
        end

        // ---------------- two pushes then drain ----------------
        out_ready = 1'b0;
        addr  = 8'hFC;
        wdata = 16'hA5A5;
        we    = 1'b1;
        #1;
        check("push1_no_bypass", 32'(out_valid), 0);
        step();
        we = 1'b0;
        check("push1_valid", 32'(out_valid), 1);
        check("push1_data", 32'(out_data), 32'h0000_A5A5);
        wr(8'hFC, 16'h1234);
        rd_chk("two_status", 8'hFD, 16'h0010);
        check("hold_data", 32'(out_data), 32'h0000_A5A5);
        out_ready = 1'b1;
        #1;
        check("pop_a5a5", 32'(out_data), 32'h0000_A5A5);
        step();
        check("pop_1234", 32'(out_data), 32'h0000_1234);
        check("pop_1234_valid", 32'(out_valid), 1);
        step();
        check("drained_valid", 32'(out_valid), 0);
        out_ready = 1'b0;

        // ---------------- overflow ----------------
        for (int i = 1; i <= 5; i++) begin
            wr(8'hFC, 16'(i));
        end
        rd_chk("full_status", 8'hFD, 16'h0026);
        check("full_head", 32'(out_data), 1);
        addr      = 8'hFC;
        wdata     = 16'h0006;
        we        = 1'b1;
        out_ready = 1'b1;
        step();
        we        = 1'b0;
        out_ready = 1'b0;
        rd_chk("push_pop_full_status", 8'hFD, 16'h001C);
        wr(8'hFD, 16'h0000);
        rd_chk("ovf_clear_status", 8'hFD, 16'h0018);
        out_ready = 1'b1;
        for (int v = 2; v <= 4; v++) begin
            #1;
            check($sformatf("drain_%0d", v), 32'(out_data), 32'(v));
            step();
        end
        check("drain_empty", 32'(out_valid), 0);
        out_ready = 1'b0;

        // ---------------- push into empty with ready high ----------------
        out_ready = 1'b1;
        addr  = 8'hFC;
        wdata = 16'hBEEF;
        we    = 1'b1;
        #1;
        check("empty_push_no_bypass", 32'(out_valid), 0);
        step();
        we = 1'b0;
        check("empty_push_valid", 32'(out_valid), 1);
        check("empty_push_data", 32'(out_data), 32'h0000_BEEF);
        rd_chk("empty_push_status", 8'hFD, 16'h0008);
        step();
        check("empty_push_popped", 32'(out_valid), 0);
        out_ready = 1'b0;

        // ---------------- randomized against queue model ----------------
        do_reset();
        q.delete();
        ovf_m = 1'b0;
        addr_pool = '{8'hFC, 8'hFC, 8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'hFB, 8'h00};
        for (int it = 0; it < 400; it++) begin
            int          sz;
            bit          e_hit;
            logic [1:0]  off;
            bit          push_req;
            bit          clr;
            addr      = addr_pool[$urandom_range(0, 7)];
            we        = ($urandom_range(0, 1) == 1);
            wdata     = 16'($urandom);
            out_ready = ($urandom_range(0, 3) == 0);
            #1;
            sz    = q.size();
            e_hit = (addr >= 8'hFC);
            off   = addr[1:0];
            check("rnd_hit", 32'(hit), 32'(e_hit));
            check("rnd_valid", 32'(out_valid), 32'(sz > 0));
            check("rnd_data", 32'(out_data), (sz > 0) ? 32'(q[0]) : 32'h0);
            if (e_hit && off == 2'd0) check("rnd_txdata_rd", 32'(rdata), 0);
            if (e_hit && off == 2'd1) check("rnd_status", 32'(rdata), 32'(model_status(sz, ovf_m)));
`ifndef DMIO_CYCLE_EN
            if (e_hit && off[1]) check("rnd_cyc_off_rd", 32'(rdata), 0);
`endif
            push_req = we && e_hit && (off == 2'd0);
            clr      = we && e_hit && (off == 2'd1);
            if (push_req && sz == DEPTH) ovf_m = 1'b1;
            else if (clr) ovf_m = 1'b0;
            if (sz > 0 && out_ready) void'(q.pop_front());
            if (push_req && sz < DEPTH) q.push_back(wdata);
            step();
        end
        we = 1'b0;
        out_ready = 1'b0;

        // ---------------- cycle counter ----------------
`ifdef DMIO_CYCLE_EN
        wr(8'hFF, 16'h0001);
        rd_chk("cyc_0", 8'hFE, 16'h0000);
        step();
        rd_chk("cyc_1", 8'hFE, 16'h0001);
        step();
        rd_chk("cyc_2", 8'hFE, 16'h0002);
        repeat (16'hFFFD) step();
        rd_chk("cyc_max", 8'hFE, 16'hFFFF);
        rd_chk("cyc_nowrap", 8'hFF, 16'h0000);
        step();
        rd_chk("cyc_wrapped", 8'hFE, 16'h0000);
        rd_chk("cyc_wrap_flag", 8'hFF, 16'h0001);
        wr(8'hFF, 16'h0001);
        rd_chk("cyc_wrap_clr", 8'hFF, 16'h0000);
        rd_chk("cyc_after_clr", 8'hFE, 16'h0000);
`else
        wr(8'hFE, 16'hFFFF);
        wr(8'hFF, 16'h0001);
        rd_chk("nocyc_fe", 8'hFE, 16'h0000);
        rd_chk("nocyc_ff", 8'hFF, 16'h0000);
        check("nocyc_hit", 32'(hit), 1);
`endif

        // ---------------- async reset mid-transfer ----------------
        for (int i = 0; i < 3; i++) begin
            wr(8'hFC, 16'(16'h0100 + i));
        end
        check("pre_rst_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_valid", 32'(out_valid), 0);
        check("rst_async_data", 32'(out_data), 0);
        @(negedge clk);
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        rd_chk("rst_after_status", 8'hFD, 16'h0001);
        check("rst_after_valid", 32'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmio.md
Name: dmio

Overview:
Memory-mapped I/O responder on the processor's data-memory port (address, write data, write enable, read data).
- Claims a 4-word window at IO_BASE; the top mux selects rdata over dmem read data when hit=1.
- Processor stores to TXDATA are pushed into a small FIFO, which an external consumer drains over a valid/ready handshake.
- A free-running cycle counter is readable for software timing.

Parameters:
- DW, 16, data width (matches processor word; must be ≥ 8)
- AW, 8, data-memory address width
- IO_BASE, 8'hFC, window base; low 2 bits must be 0
- DEPTH, 4, FIFO entries; power of two, 2..8

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- addr  in  AW  data-memory address from processor
- wdata  in  DW  store data
- we  in  1  store enable
- hit  out  1  addr lies in window; combinational
- rdata  out  DW  read data for window; combinational, same cycle as addr
- out_data  out  DW  FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head this cycle

Behaviour:
- Reset (rst=0, async): FIFO empty, rd/wr pointers 0, count 0, overflow 0, cycle 0, wrap 0; out_valid=0, out_data=0.
- hit = (addr[AW-1:2] == IO_BASE[AW-1:2]). Register writes require we & hit, take effect at the next clk edge. Reads need no strobe.
- Offset 0 TXDATA:
  - write pushes wdata when FIFO not full
  - when full: write dropped, overflow set (sticky)
  - read returns 0
- Offset 1 STATUS:
  - read = {zeros, count[4:0] in bits 7:3, overflow bit2, full bit1, empty bit0}
  - any write clears overflow
  - if a dropped push and a clear coincide: set wins
- Offset 2 CYCLE:
  - read = cycle counter
  - counter increments every clk, wraps 2^DW-1 -> 0; wrap sets sticky wrap flag
- Offset 3 CYCCTL:
  - read = {zeros, wrap}
  - write with wdata[0]=1 clears counter and wrap; counter reads 0 the following cycle
  - clear beats increment
- Pop: out_valid & out_ready at clk edge; head advances, count decrements.
- Simultaneous push and pop:
  - fullness is judged on pre-edge state, so a push while full is dropped even if a pop occurs in the same cycle
  - not full: both happen, count unchanged
- Empty -> first push: out_valid rises the cycle after the write edge; no same-cycle bypass.
- out_data is stable while out_valid=1 and out_ready=0.
- Pointers wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0).
- Reset asserted mid-transfer discards all FIFO contents; out_valid drops immediately (async).

Optional Feature:
DMIO_CYCLE_EN
- Defined: cycle counter, wrap flag, offsets 2/3 as described.
- Undefined: no counter logic; offsets 2 and 3 read 0, writes ignored. hit is unchanged (window stays 4 words).

Decomposition:
- Shared header/package (pu.vh): DMIO offset constants (TXDATA=0, STATUS=1, CYCLE=2, CYCCTL=3), STATUS bit positions, default IO_BASE.
- One sub-module: dmio_fifo (DEPTH x DW, push/pop, count, full/empty). Register decode, rdata mux and counter live in dmio.

Test Plan:
- Reset then idle -> out_valid=0; STATUS read = 16'h0001; hit=0 for addr 8'hFB, hit=1 for 8'hFC..8'hFF.
- Write 16'hA5A5, 16'h1234 to 8'hFC with out_ready=0 -> out_valid=1 the cycle after the first write; STATUS = 16'h0010; then out_ready=1 -> out_data A5A5, then 1234, then out_valid=0.
- Five pushes, out_ready=0 -> fifth dropped; STATUS = 16'h0026 (count 4, overflow, full). A push together with a pop while full is still dropped (count becomes 3). Write STATUS -> overflow cleared.
- Push while empty concurrent with out_ready=1 -> no pop that cycle; data appears next cycle, popped following cycle.
- DMIO_CYCLE_EN: write 1 to 8'hFF -> CYCLE reads 0, then 1, 2, ...; force past 16'hFFFF -> wraps to 0, 8'hFF reads 1. Without the macro, 8'hFE reads 0.
- Assert rst low with 3 entries queued mid-pop -> out_valid=0 immediately; after release, STATUS = 16'h0001.
